// File: rtl/crtc_mode_loader.sv
// Bus initiator that programs a crtc6845 register file with one of four built-in video modes
// through its index/data port, and can then read every register back and compare it.
module crtc_mode_loader #(
  parameter bit          WORD_MODE = 1'b0,
  parameter bit          VERIFY    = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [13:0] start_addr,
  input  logic [13:0] cursor_addr,
  input  logic        lock_in,
  input  logic [7:0]  crtc_bus_out,
  output logic        cs,
  output logic        a0,
  output logic        word,
  output logic        write,
  output logic        read,
  output logic [15:0] bus,
  output logic        crtc_lock,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  err_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_IDX, S_W_DAT, S_W_WRD, S_GAP, S_V_IDX, S_V_CMP, S_DONE
  } state_t;

  // Element 0 is the leftmost entry, so each row reads R0..R7,R9,R10,R11.
  localparam logic [0:10][7:0] TBL_M0 = {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h07, 8'h06, 8'h07};
  localparam logic [0:10][7:0] TBL_M1 = {8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h07, 8'h06, 8'h07};
  localparam logic [0:10][7:0] TBL_M2 = {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h01, 8'h06, 8'h07};
  localparam logic [0:10][7:0] TBL_M3 = {8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h0D, 8'h0B, 8'h0C};
  localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t      state, state_next, ret_state, ret_next, after;
  logic        xfer, last;
  logic [3:0]  pos, gap_cnt;
  logic [1:0]  mode_q;
  logic [13:0] sa_q, ca_q;
  logic [4:0]  idx;
  logic [7:0]  data, mask;

  // pos walks the 15 implemented registers; R8 is skipped when forming the index.
  assign idx  = (pos < 4'd8) ? {1'b0, pos} : {1'b0, pos} + 5'd1;
  assign last = (pos == 4'd14);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    data = 8'h00;
    unique case (pos)
      4'd11:   data = {2'b00, sa_q[13:8]};
      4'd12:   data = sa_q[7:0];
      4'd13:   data = {2'b00, ca_q[13:8]};
      4'd14:   data = ca_q[7:0];
      default: if (pos <= 4'd10) begin
        unique case (mode_q)
          2'd0: data = TBL_M0[pos];
          2'd1: data = TBL_M1[pos];
          2'd2: data = TBL_M2[pos];
          2'd3: data = TBL_M3[pos];
        endcase
      end
    endcase
  end

  // Only the bits the CRTC actually implements take part in the readback compare.
  always_comb begin
    mask = 8'hFF;
    unique case (pos)
      4'd3:                     mask = 8'h0F;
      4'd4, 4'd6, 4'd7, 4'd9:   mask = 8'h7F;
      4'd5, 4'd8, 4'd10:        mask = 8'h1F;
      4'd11, 4'd13:             mask = 8'h3F;
      default:                  mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    after      = S_IDLE;
    xfer       = 1'b0;
    cs         = 1'b0;
    a0         = 1'b0;
    word       = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    bus        = 16'h0000;
    unique case (state)
      S_IDLE: if (start) state_next = WORD_MODE ? S_W_WRD : S_W_IDX;
      S_W_IDX: begin
        cs = 1'b1; write = 1'b1; bus = {8'h00, 3'b000, idx};
        xfer = 1'b1; after = S_W_DAT;
      end
      S_W_DAT: begin
        cs = 1'b1; a0 = 1'b1; write = 1'b1; bus = {8'h00, data};
        xfer = 1'b1; after = last ? (VERIFY ? S_V_IDX : S_DONE) : S_W_IDX;
      end
      S_W_WRD: begin
        cs = 1'b1; word = 1'b1; write = 1'b1; bus = {data, 3'b000, idx};
        xfer = 1'b1; after = last ? (VERIFY ? S_V_IDX : S_DONE) : S_W_WRD;
      end
      S_GAP: if (gap_cnt == 4'd0) state_next = ret_state;
      S_V_IDX: begin
        cs = 1'b1; write = 1'b1; bus = {8'h00, 3'b000, idx};
        xfer = 1'b1; after = S_V_CMP;
      end
      S_V_CMP: begin
        cs = 1'b1; a0 = 1'b1; read = 1'b1;
        xfer = 1'b1; after = last ? S_DONE : S_V_IDX;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (xfer) begin
      if (GAP == 0) begin
        state_next = after;
      end else begin
        state_next = S_GAP;
        ret_next   = after;
      end
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign crtc_lock = lock_in & (state == S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      pos       <= 4'd0;
      gap_cnt   <= 4'd0;
      mode_q    <= 2'd0;
      sa_q      <= 14'd0;
      ca_q      <= 14'd0;
      error     <= 1'b0;
      err_idx   <= 5'd0;
    end else begin
      state     <= state_next;
      ret_state <= ret_next;
      if (state == S_IDLE && start) begin
        mode_q  <= mode;
        sa_q    <= start_addr;
        ca_q    <= cursor_addr;
        error   <= 1'b0;
        err_idx <= 5'd0;
        pos     <= 4'd0;
      end
      if (xfer) gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      if (state == S_W_DAT || state == S_W_WRD || state == S_V_CMP)
        pos <= last ? 4'd0 : pos + 4'd1;
      // Only the first mismatch is recorded; verify still runs through R15.
      if (state == S_V_CMP && !error && ((crtc_bus_out ^ data) & mask) != 8'h00) begin
        error   <= 1'b1;
        err_idx <= idx;
      end
    end
  end

endmodule
